// File: rtl/branch_pc_unit_pkg.sv
// Shared opcode encoding and branch-condition evaluation for the PC unit.
package branch_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_JMP  = 4'd0;
  localparam logic [OP_W-1:0] OP_JE   = 4'd1;
  localparam logic [OP_W-1:0] OP_JA   = 4'd2;
  localparam logic [OP_W-1:0] OP_JB   = 4'd3;
  localparam logic [OP_W-1:0] OP_JAE  = 4'd4;
  localparam logic [OP_W-1:0] OP_JBE  = 4'd5;
  localparam logic [OP_W-1:0] OP_JNE  = 4'd6;
  localparam logic [OP_W-1:0] OP_CALL = 4'd7;
  localparam logic [OP_W-1:0] OP_RET  = 4'd8;

  // Reserved encodings (9..15) are never taken.
  function automatic logic branch_cond(input logic [OP_W-1:0] op,
                                       input logic zf,
                                       input logic cf);
    logic c;
    c = 1'b0;
    case (op)
      OP_JMP:  c = 1'b1;
      OP_JE:   c = zf;
      OP_JA:   c = ~zf & ~cf;
      OP_JB:   c = cf;
      OP_JAE:  c = ~cf;
      OP_JBE:  c = cf | zf;
      OP_JNE:  c = ~zf;
      OP_CALL: c = 1'b1;
      OP_RET:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control-side bundle for the PC unit: the control unit is master, the PC unit is slave.
interface branch_pc_unit_if
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int OFFSET_W    = 11,
  parameter int STACK_DEPTH = 8
);
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  logic                step;
  logic                jump_en;
  logic [OP_W-1:0]     op;
  logic [OFFSET_W-1:0] offset;
  logic                flag_we;
  logic                zf_in;
  logic                cf_in;
  logic                err_clr;
  logic [ADDR_W-1:0]   pc;
  logic                taken;
  logic [CNT_W-1:0]    stack_count;
  logic                stack_ovf;
  logic                stack_unf;

  modport master (
    output step, jump_en, op, offset, flag_we, zf_in, cf_in, err_clr,
    input  pc, taken, stack_count, stack_ovf, stack_unf
  );

  modport slave (
    input  step, jump_en, op, offset, flag_we, zf_in, cf_in, err_clr,
    output pc, taken, stack_count, stack_ovf, stack_unf
  );
endinterface

// File: rtl/branch_pc_unit_ret_stack.sv
// LIFO of return addresses: synchronous push, combinational top-of-stack read.
module ret_stack
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 8,
  localparam int PW         = $clog2(STACK_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     w_wr_idx;
  logic [PW-1:0]     w_rd_idx;

  assign w_wr_idx = r_count[PW-1:0];
  assign w_rd_idx = PW'(r_count - CW'(1));
  assign full     = (r_count == CW'(STACK_DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign dout     = r_mem[w_rd_idx];

  // Entries are never cleared; only the count is reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_count <= r_count + CW'(1);
    end else if (pop && !empty) begin
      r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with flag register, conditional relative branches and CALL/RET via a return stack.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int OFFSET_W    = 11,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  branch_pc_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_taken;
  logic              r_zf;
  logic              r_cf;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_taken_next;
  logic              w_cond;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [ADDR_W-1:0] w_top;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;

  assign w_seq  = r_pc + ADDR_W'(1);
  assign w_tgt  = r_pc + ADDR_W'(signed'(bus.offset));
  // Branches see only the registered flags, so flag inputs never reach pc combinationally.
  assign w_cond = branch_cond(bus.op, r_zf, r_cf);

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_seq),
    .dout  (w_top),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_pc_next    = r_pc;
    w_taken_next = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    if (bus.step) begin
      w_pc_next = w_seq;
      if (bus.jump_en) begin
        if (bus.op <= OP_JNE) begin
          w_pc_next    = w_cond ? w_tgt : w_seq;
          w_taken_next = w_cond;
        end else if (bus.op == OP_CALL) begin
          if (!w_full) begin
            w_push       = 1'b1;
            w_pc_next    = w_tgt;
            w_taken_next = 1'b1;
          end else begin
            w_ovf_set = 1'b1;
          end
        end else if (bus.op == OP_RET) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_pc_next    = w_top;
            w_taken_next = 1'b1;
          end else begin
            w_unf_set = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_taken <= w_taken_next;
      if (bus.flag_we) begin
        r_zf <= bus.zf_in;
        r_cf <= bus.cf_in;
      end
      // A fault in the same cycle as err_clr keeps its flag set.
      r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr);
      r_unf <= w_unf_set | (r_unf & ~bus.err_clr);
    end
  end

  assign bus.pc          = r_pc;
  assign bus.taken       = r_taken;
  assign bus.stack_count = w_count;
  assign bus.stack_ovf   = r_ovf;
  assign bus.stack_unf   = r_unf;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed tests for branch_pc_unit: sequencing, conditions, wrap, CALL/RET, stack faults, same-cycle hazards.
module tb_branch_pc_unit;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_pc_unit_if #(.ADDR_W(11), .OFFSET_W(11), .STACK_DEPTH(8)) bus ();

  branch_pc_unit #(.ADDR_W(11), .OFFSET_W(11), .STACK_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.step    = 1'b0;
    bus.jump_en = 1'b0;
    bus.op      = '0;
    bus.offset  = '0;
    bus.flag_we = 1'b0;
    bus.zf_in   = 1'b0;
    bus.cf_in   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic step_op(input logic je, input logic [3:0] o, input logic [10:0] off);
    bus.step    = 1'b1;
    bus.jump_en = je;
    bus.op      = o;
    bus.offset  = off;
    tick();
    clear_inputs();
  endtask

  task automatic set_flags(input logic z, input logic c);
    bus.flag_we = 1'b1;
    bus.zf_in   = z;
    bus.cf_in   = c;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.pc !== 11'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", bus.pc); end
    n_cmp++; if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got=%b exp=0", bus.taken); end
    n_cmp++; if (bus.stack_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.stack_count); end
    n_cmp++; if ({bus.stack_ovf, bus.stack_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {bus.stack_ovf, bus.stack_unf}); end
    for (int i = 1; i <= 3; i++) begin
      step_op(1'b0, OP_JMP, 11'd9);
      n_cmp++; if (bus.pc !== 11'(i) || bus.taken !== 1'b0) begin n_fail++; $display("FAIL seq_step%0d got pc=%0d taken=%b exp pc=%0d taken=0", i, bus.pc, bus.taken, i); end
    end
    n_cmp++; if (bus.stack_count !== 4'd0) begin n_fail++; $display("FAIL seq_count got=%0d exp=0", bus.stack_count); end
    $display("test_reset done: pc=%0d", bus.pc);
  endtask

  task automatic test_cond();
    do_reset();
    set_flags(1'b1, 1'b0);
    step_op(1'b1, OP_JMP, 11'd10);
    n_cmp++; if (bus.pc !== 11'd10 || bus.taken !== 1'b1) begin n_fail++; $display("FAIL jmp10 got pc=%0d taken=%b exp pc=10 taken=1", bus.pc, bus.taken); end
    step_op(1'b1, OP_JE, 11'd5);
    n_cmp++; if (bus.pc !== 11'd15 || bus.taken !== 1'b1) begin n_fail++; $display("FAIL je_taken got pc=%0d taken=%b exp pc=15 taken=1", bus.pc, bus.taken); end
    step_op(1'b1, OP_JA, 11'd5);
    n_cmp++; if (bus.pc !== 11'd16 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL ja_not got pc=%0d taken=%b exp pc=16 taken=0", bus.pc, bus.taken); end
    tick();
    n_cmp++; if (bus.pc !== 11'd16 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL hold got pc=%0d taken=%b exp pc=16 taken=0", bus.pc, bus.taken); end
    step_op(1'b1, OP_JNE, 11'd4);
    n_cmp++; if (bus.pc !== 11'd17) begin n_fail++; $display("FAIL jne_not got pc=%0d exp=17", bus.pc); end
    step_op(1'b1, 4'd12, 11'd4);
    n_cmp++; if (bus.pc !== 11'd18 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL reserved got pc=%0d taken=%b exp pc=18 taken=0", bus.pc, bus.taken); end
    $display("test_cond done: pc=%0d", bus.pc);
  endtask

  task automatic test_jb_wrap();
    do_reset();
    set_flags(1'b0, 1'b1);
    step_op(1'b1, OP_JMP, 11'd20);
    step_op(1'b1, OP_JB, 11'h7FC);
    n_cmp++; if (bus.pc !== 11'd16 || bus.taken !== 1'b1) begin n_fail++; $display("FAIL jb_back got pc=%0d taken=%b exp pc=16 taken=1", bus.pc, bus.taken); end
    step_op(1'b1, OP_JAE, 11'd5);
    n_cmp++; if (bus.pc !== 11'd17) begin n_fail++; $display("FAIL jae_not got pc=%0d exp=17", bus.pc); end
    step_op(1'b1, OP_JBE, 11'd3);
    n_cmp++; if (bus.pc !== 11'd20) begin n_fail++; $display("FAIL jbe_taken got pc=%0d exp=20", bus.pc); end
    step_op(1'b1, OP_JMP, 11'd2027);
    n_cmp++; if (bus.pc !== 11'd2047) begin n_fail++; $display("FAIL to_top got pc=%0d exp=2047", bus.pc); end
    step_op(1'b0, OP_JMP, 11'd0);
    n_cmp++; if (bus.pc !== 11'd0) begin n_fail++; $display("FAIL wrap got pc=%0d exp=0", bus.pc); end
    $display("test_jb_wrap done: pc=%0d", bus.pc);
  endtask

  task automatic test_call_ret();
    do_reset();
    step_op(1'b1, OP_JMP, 11'd100);
    step_op(1'b1, OP_CALL, 11'd50);
    n_cmp++; if (bus.pc !== 11'd150 || bus.stack_count !== 4'd1 || bus.taken !== 1'b1) begin n_fail++; $display("FAIL call got pc=%0d cnt=%0d taken=%b exp 150/1/1", bus.pc, bus.stack_count, bus.taken); end
    step_op(1'b1, OP_RET, 11'd7);
    n_cmp++; if (bus.pc !== 11'd101 || bus.stack_count !== 4'd0 || bus.taken !== 1'b1) begin n_fail++; $display("FAIL ret got pc=%0d cnt=%0d taken=%b exp 101/0/1", bus.pc, bus.stack_count, bus.taken); end
    $display("test_call_ret done: pc=%0d", bus.pc);
  endtask

  task automatic test_stack_faults();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step_op(1'b1, OP_CALL, 11'd10);
      n_cmp++; if (bus.pc !== 11'(10 * k) || bus.stack_count !== 4'(k)) begin n_fail++; $display("FAIL call%0d got pc=%0d cnt=%0d exp %0d/%0d", k, bus.pc, bus.stack_count, 10 * k, k); end
    end
    step_op(1'b1, OP_CALL, 11'd10);
    n_cmp++; if (bus.pc !== 11'd81 || bus.stack_count !== 4'd8 || bus.stack_ovf !== 1'b1 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL call_ovf got pc=%0d cnt=%0d ovf=%b taken=%b exp 81/8/1/0", bus.pc, bus.stack_count, bus.stack_ovf, bus.taken); end
    for (int k = 8; k >= 1; k--) begin
      step_op(1'b1, OP_RET, 11'd0);
      n_cmp++; if (bus.pc !== 11'(10 * k - 9) || bus.stack_count !== 4'(k - 1)) begin n_fail++; $display("FAIL ret%0d got pc=%0d cnt=%0d exp %0d/%0d", k, bus.pc, bus.stack_count, 10 * k - 9, k - 1); end
    end
    step_op(1'b1, OP_RET, 11'd0);
    n_cmp++; if (bus.pc !== 11'd2 || bus.stack_unf !== 1'b1 || bus.stack_ovf !== 1'b1 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL ret_unf got pc=%0d unf=%b ovf=%b taken=%b exp 2/1/1/0", bus.pc, bus.stack_unf, bus.stack_ovf, bus.taken); end
    bus.err_clr = 1'b1;
    step_op(1'b1, OP_RET, 11'd0);
    n_cmp++; if ({bus.stack_ovf, bus.stack_unf} !== 2'b01) begin n_fail++; $display("FAIL set_wins got ovf,unf=%b exp 01", {bus.stack_ovf, bus.stack_unf}); end
    bus.err_clr = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if ({bus.stack_ovf, bus.stack_unf} !== 2'b00) begin n_fail++; $display("FAIL err_clr got ovf,unf=%b exp 00", {bus.stack_ovf, bus.stack_unf}); end
    $display("test_stack_faults done: pc=%0d", bus.pc);
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.flag_we = 1'b1;
    bus.zf_in   = 1'b1;
    step_op(1'b1, OP_JE, 11'd7);
    n_cmp++; if (bus.pc !== 11'd1 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL je_old_flag got pc=%0d taken=%b exp pc=1 taken=0", bus.pc, bus.taken); end
    step_op(1'b1, OP_JE, 11'd7);
    n_cmp++; if (bus.pc !== 11'd8 || bus.taken !== 1'b1) begin n_fail++; $display("FAIL je_new_flag got pc=%0d taken=%b exp pc=8 taken=1", bus.pc, bus.taken); end
    step_op(1'b1, OP_CALL, 11'd2);
    n_cmp++; if (bus.pc !== 11'd10 || bus.stack_count !== 4'd1) begin n_fail++; $display("FAIL pre_rst_call got pc=%0d cnt=%0d exp 10/1", bus.pc, bus.stack_count); end
    rst = 1'b1;
    step_op(1'b1, OP_CALL, 11'd2);
    rst = 1'b0;
    n_cmp++; if (bus.pc !== 11'd0 || bus.stack_count !== 4'd0 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL rst_call got pc=%0d cnt=%0d taken=%b exp 0/0/0", bus.pc, bus.stack_count, bus.taken); end
    $display("test_same_cycle done: pc=%0d", bus.pc);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cond();
    test_jb_wrap();
    test_call_ret();
    test_stack_faults();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
